// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmitter arbiter.
// State encoding is exported on the debug port, so its values are fixed.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND       = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_HOLD       = 3'd4
  } state_t;

  localparam int START_TIMEOUT_DEF = 16;
  localparam int HOLD_TIMEOUT_DEF  = 255;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; the owner of ptr updates it.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic [N-1:0] rot;
  int           k;
  int           sum;

  // Rotate so ptr lands on bit 0, then find the lowest set bit.
  always_comb begin
    rot     = N'({req, req} >> ptr);
    any     = 1'b0;
    k       = 0;
    sum     = 0;
    win_oh  = '0;
    win_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        k   = j;
      end
    end
    sum = int'(ptr) + k;
    if (sum >= N) sum = sum - N;
    if (any) begin
      win_idx = IW'(sum);
      win_oh  = N'(1) << sum;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX between N_REQ requesters, round-robin,
// with optional frame lock until the requester flags its last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF,
  parameter int HOLD_TIMEOUT  = HOLD_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_busy,
  output logic [7:0]         txdata,
  output logic               wr_en,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW =
    $clog2(max_int(START_TIMEOUT, HOLD_TIMEOUT));

  state_t            state_q, state_d;
  logic [7:0]        txdata_q, txdata_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              lock_end_q, lock_end_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [IW-1:0]     nxt_ptr;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    nxt_ptr = '0;
    if (int'(idx_q) != N_REQ - 1) nxt_ptr = idx_q + IW'(1);
  end

  always_comb begin
    state_d    = state_q;
    txdata_d   = txdata_q;
    ack_d      = '0;
    grant_d    = grant_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    lock_end_d = lock_end_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!tx_busy && pick_any) begin
          txdata_d   = req_data[8*int'(pick_idx) +: 8];
          lock_end_d = last[pick_idx];
          grant_d    = pick_oh;
          idx_d      = pick_idx;
          ack_d      = pick_oh;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_d = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (tx_busy ||
            timer_q == TW'(START_TIMEOUT - 1)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_end_q) begin
            grant_d  = '0;
            rr_ptr_d = nxt_ptr;
            state_d  = ST_IDLE;
          end else begin
            timer_d = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Only the lock owner may continue; busy still blocks a write.
        if (req[idx_q] && !tx_busy) begin
          txdata_d   = req_data[8*int'(idx_q) +: 8];
          lock_end_d = last[idx_q];
          ack_d      = grant_q;
          state_d    = ST_SEND;
        end else if (timer_q == TW'(HOLD_TIMEOUT - 1)) begin
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      txdata_q   <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      lock_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txdata_q   <= txdata_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      lock_end_q <= lock_end_d;
    end
  end

  assign txdata = txdata_q;
  assign wr_en  = (state_q == ST_SEND);
  assign ack    = ack_q;
  assign grant  = grant_q;
  assign state  = state_q;

endmodule
